// File: rtl/data_mem_pkg.sv
// Shared constants and types for the parametrised RV32I data memory.
package data_mem_pkg;

    // sign_mask[2:0] size encodings; bit 3 selects sign extension
    localparam logic [2:0]  SM_BYTE     = 3'b001;
    localparam logic [2:0]  SM_HALF     = 3'b011;
    localparam logic [2:0]  SM_WORD     = 3'b111;
    localparam int unsigned SM_SIGN_BIT = 3;

    localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    // Undefined encodings fall back to a full-word access
    function automatic size_e decode_size(input logic [2:0] mask);
        size_e sz;
        case (mask)
            SM_BYTE: sz = SZ_BYTE;
            SM_HALF: sz = SZ_HALF;
            SM_WORD: sz = SZ_WORD;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// Combinational byte-lane logic: merges sub-word store data into an old word
// and extracts/extends the selected lanes of a word for loads.
module data_mem_lane
    import data_mem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [1:0]  offset_i,
    input  logic [3:0]  mask_i,
    input  logic [15:0] store_data_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    size_e       size;
    logic        sign_ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign size     = decode_size(mask_i[2:0]);
    assign sign_ext = mask_i[SM_SIGN_BIT];

    // Store merge: replace the addressed byte or halfword lanes
    always_comb begin
        merged_o = old_word_i;
        case (size)
            SZ_BYTE: merged_o[{offset_i, 3'b000} +: 8]     = store_data_i[7:0];
            SZ_HALF: merged_o[{offset_i[1], 4'b0000} +: 16] = store_data_i;
            default: merged_o = old_word_i;
        endcase
    end

    // Load extraction: halfword ignores offset[0], word ignores both offset bits
    always_comb begin
        byte_sel = old_word_i[{offset_i, 3'b000} +: 8];
        half_sel = old_word_i[{offset_i[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: load_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_o = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_param.sv
// Parametrised data memory for the RV32I MEM stage: byte/half/word loads and
// stores, a memory-mapped LED register and an out-of-range access fault.
// Word stores complete in one cycle; sub-word stores read-modify-write through
// a one-cycle MERGE state that raises clk_stall.
// Optional: define DATA_MEM_MISALIGN_CHECK_EN to fault misaligned half/word
// accesses instead of masking the low address bits.
module data_mem_param
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] LED_ADDR    = LED_ADDR_DEFAULT,
    parameter int unsigned LED_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          addr,
    input  logic [31:0]          write_data,
    input  logic                 memwrite,
    input  logic                 memread,
    input  logic [3:0]           sign_mask,
    output logic [31:0]          read_data,
    output logic [LED_WIDTH-1:0] led,
    output logic                 clk_stall,
    output logic                 access_fault
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    logic [31:0] mem [DEPTH_WORDS];

    state_e               state_q, state_d;
    logic                 stall_q, stall_d;
    logic                 fault_q, fault_d;
    logic [31:0]          read_data_q, read_data_d;
    logic [LED_WIDTH-1:0] led_q, led_d;

    // Pending sub-word store, held across MERGE
    logic [AW-1:0] st_idx_q, st_idx_d;
    logic [1:0]    st_off_q, st_off_d;
    logic [3:0]    st_mask_q, st_mask_d;
    logic [15:0]   st_data_q, st_data_d;
    logic [31:0]   st_old_q, st_old_d;

    logic [AW-1:0] idx;
    logic [31:0]   mem_rdata;
    logic          in_range;
    logic          is_led;
    logic          misalign;
    logic          bad_access;
    size_e         req_size;

    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

    logic [31:0]   lane_old;
    logic [1:0]    lane_off;
    logic [3:0]    lane_mask;
    logic [15:0]   lane_data;
    logic [31:0]   lane_merged;
    logic [31:0]   lane_load;

    assign idx       = AW'((addr - BASE_ADDR) >> 2);
    assign mem_rdata = mem[idx];
    assign in_range  = (addr >= BASE_ADDR) && ({1'b0, addr} < END_ADDR);
    assign is_led    = (addr == LED_ADDR);
    assign req_size  = decode_size(sign_mask[2:0]);

`ifdef DATA_MEM_MISALIGN_CHECK_EN
    assign misalign = ((req_size == SZ_HALF) && addr[0]) ||
                      ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad_access = !in_range || misalign;

    // Lane logic serves the pending store in MERGE and the live request otherwise
    always_comb begin
        lane_old  = mem_rdata;
        lane_off  = addr[1:0];
        lane_mask = sign_mask;
        lane_data = write_data[15:0];
        if (state_q == ST_MERGE) begin
            lane_old  = st_old_q;
            lane_off  = st_off_q;
            lane_mask = st_mask_q;
            lane_data = st_data_q;
        end
    end

    data_mem_lane u_lane (
        .old_word_i   (lane_old),
        .offset_i     (lane_off),
        .mask_i       (lane_mask),
        .store_data_i (lane_data),
        .merged_o     (lane_merged),
        .load_o       (lane_load)
    );

    // Next-state, memory write port and output register inputs
    always_comb begin
        state_d     = state_q;
        stall_d     = 1'b0;
        fault_d     = 1'b0;
        read_data_d = read_data_q;
        led_d       = led_q;
        st_idx_d    = st_idx_q;
        st_off_d    = st_off_q;
        st_mask_d   = st_mask_q;
        st_data_d   = st_data_q;
        st_old_d    = st_old_q;
        mem_we      = 1'b0;
        mem_widx    = idx;
        mem_wdata   = write_data;

        case (state_q)
            ST_IDLE: begin
                if (memwrite) begin
                    // A simultaneous read is ignored; read_data holds
                    if (is_led) begin
                        led_d = write_data[LED_WIDTH-1:0];
                    end else if (bad_access) begin
                        fault_d = 1'b1;
                    end else if (req_size == SZ_WORD) begin
                        mem_we = 1'b1;
                    end else begin
                        st_idx_d  = idx;
                        st_off_d  = addr[1:0];
                        st_mask_d = sign_mask;
                        st_data_d = write_data[15:0];
                        st_old_d  = mem_rdata;
                        state_d   = ST_MERGE;
                        stall_d   = 1'b1;
                    end
                end else if (memread) begin
                    if (is_led) begin
                        read_data_d = 32'(led_q);
                    end else if (bad_access) begin
                        read_data_d = 32'h0;
                        fault_d     = 1'b1;
                    end else begin
                        read_data_d = lane_load;
                    end
                end
            end
            ST_MERGE: begin
                mem_we    = 1'b1;
                mem_widx  = st_idx_q;
                mem_wdata = lane_merged;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers; async reset drops any pending merge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            stall_q     <= 1'b0;
            fault_q     <= 1'b0;
            read_data_q <= 32'h0;
            led_q       <= '0;
            st_idx_q    <= '0;
            st_off_q    <= 2'b00;
            st_mask_q   <= 4'h0;
            st_data_q   <= 16'h0;
            st_old_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            fault_q     <= fault_d;
            read_data_q <= read_data_d;
            led_q       <= led_d;
            st_idx_q    <= st_idx_d;
            st_off_q    <= st_off_d;
            st_mask_q   <= st_mask_d;
            st_data_q   <= st_data_d;
            st_old_q    <= st_old_d;
        end
    end

    // Storage array: contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign read_data    = read_data_q;
    assign led          = led_q;
    assign clk_stall    = stall_q;
    assign access_fault = fault_q;

endmodule
